// File: rtl/seg_scan_counter.sv
// rtl/seg_scan_counter.sv - Up/down BCD or hex counter with multiplexed 7-segment scan
module seg_scan_counter #(
  parameter int NDIG     = 4,
  parameter int BCD      = 1,
  parameter int STEP_DIV = 12000000,
  parameter int SCAN_DIV = 3000,
  parameter int BLANK    = 60
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              UP,
  input  logic              CLR,
  output logic [6:0]        SEG,
  output logic [NDIG-1:0]   COMM,
  output logic [4*NDIG-1:0] COUNT,
  output logic              WRAP,
  output logic [3:0]        DBG
);

  localparam int SW = $clog2(STEP_DIV);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [3:0]    DMAX       = (BCD != 0) ? 4'd9 : 4'd15;
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_DIV - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  typedef enum logic {BLANKING = 1'b0, DRIVE = 1'b1} state_t;

  logic [SW-1:0]     step_q;
  logic              tick;
  logic [4*NDIG-1:0] count_nxt;
  logic              chain_out;

  state_t            state_q, state_d;
  logic [CW-1:0]     slot_q, slot_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NDIG-1:0]   comm_d;
  logic [6:0]        seg_d;
  logic [3:0]        digit;

  // Active-high segment patterns, bit 0 = a ... bit 6 = g
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    // Non-decimal values cannot occur in BCD mode; show nothing if they do
    if ((BCD != 0) && (d > 4'd9)) s = 7'b0000000;
    return s;
  endfunction

  assign tick = (step_q == STEP_LAST);
  assign DBG  = COUNT[3:0];

  // Step prescaler: free-running, independent of EN and CLR
  always_ff @(posedge CLK) begin
    if (RST || tick) step_q <= '0;
    else             step_q <= step_q + SW'(1);
  end

  // Ripple carry/borrow chain across digits; chain_out flags a full wrap
  always_comb begin
    logic       c;
    logic [3:0] d;
    count_nxt = COUNT;
    c         = 1'b1;
    d         = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      d = COUNT[4*i +: 4];
      if (c) begin
        if (UP) begin
          if (d >= DMAX) begin
            count_nxt[4*i +: 4] = 4'd0;
          end else begin
            count_nxt[4*i +: 4] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            count_nxt[4*i +: 4] = DMAX;
          end else begin
            count_nxt[4*i +: 4] = d - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    chain_out = c;
  end

  // Count register and wrap pulse; CLR wins over a step and never flags a wrap
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      COUNT <= '0;
      WRAP  <= 1'b0;
    end else if (tick && EN) begin
      COUNT <= count_nxt;
      WRAP  <= chain_out;
    end else begin
      WRAP  <= 1'b0;
    end
  end

  // Scan state, slot timer, digit index and registered display outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= BLANKING;
      slot_q  <= '0;
      idx_q   <= '0;
      COMM    <= '1;
      SEG     <= 7'b0000000;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      COMM    <= comm_d;
      SEG     <= seg_d;
    end
  end

  // Next scan state; outputs follow the upcoming state so they line up with the slot timer
  always_comb begin
    state_d = state_q;
    slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + CW'(1);
    idx_d   = idx_q;
    comm_d  = '1;
    seg_d   = 7'b0000000;
    digit   = 4'd0;
    case (state_q)
      BLANKING: begin
        if (slot_q == BLANK_LAST) state_d = DRIVE;
      end
      DRIVE: begin
        if (slot_q == SLOT_LAST) begin
          state_d = BLANKING;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
      end
      default: state_d = BLANKING;
    endcase
    for (int i = 0; i < NDIG; i++) begin
      if (idx_d == IW'(i)) digit = COUNT[4*i +: 4];
    end
    if (state_d == DRIVE) begin
      seg_d = seg_decode(digit);
      for (int i = 0; i < NDIG; i++) begin
        comm_d[i] = (idx_d != IW'(i));
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_counter.sv
// tb/tb_seg_scan_counter.sv - Directed self-checking bench for seg_scan_counter
module tb_seg_scan_counter;

  localparam int NDIG     = 2;
  localparam int STEP_DIV = 4;
  localparam int SCAN_DIV = 8;
  localparam int BLANK    = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN  = 1'b0;
  logic       UP  = 1'b1;
  logic       CLR = 1'b0;

  logic [6:0] seg_b, seg_h;
  logic [1:0] comm_b, comm_h;
  logic [7:0] count_b, count_h;
  logic       wrap_b, wrap_h;
  logic [3:0] dbg_b, dbg_h;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  seg_scan_counter #(.NDIG(NDIG), .BCD(1), .STEP_DIV(STEP_DIV), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK)) u_bcd (
    .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .CLR(CLR),
    .SEG(seg_b), .COMM(comm_b), .COUNT(count_b), .WRAP(wrap_b), .DBG(dbg_b)
  );

  seg_scan_counter #(.NDIG(NDIG), .BCD(0), .STEP_DIV(STEP_DIV), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK)) u_hex (
    .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .CLR(CLR),
    .SEG(seg_h), .COMM(comm_h), .COUNT(count_h), .WRAP(wrap_h), .DBG(dbg_h)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [1:0] comm, input logic [7:0] cnt, input bit bcd);
    logic [3:0] d;
    if (comm == 2'b10)      d = cnt[3:0];
    else if (comm == 2'b01) d = cnt[7:4];
    else return 7'h00;
    if (bcd && (d > 4'd9)) return 7'h00;
    return seg_pattern(d);
  endfunction

  // Continuous monitors: single low common, segment decode vs previous count, one-cycle wrap
  logic [7:0] prev_b = 8'h00, prev_h = 8'h00;
  logic       pw_b = 1'b0, pw_h = 1'b0;

  always @(negedge CLK) begin
    check("comm_onehot_bcd", 32'($countones(~comm_b) <= 1), 32'd1);
    check("comm_onehot_hex", 32'($countones(~comm_h) <= 1), 32'd1);
    check("seg_decode_bcd", 32'(seg_b), 32'(exp_seg(comm_b, prev_b, 1'b1)));
    check("seg_decode_hex", 32'(seg_h), 32'(exp_seg(comm_h, prev_h, 1'b0)));
    check("wrap_single_bcd", 32'(wrap_b && pw_b), 32'd0);
    check("wrap_single_hex", 32'(wrap_h && pw_h), 32'd0);
    pw_b   = wrap_b;
    pw_h   = wrap_h;
    prev_b = count_b;
    prev_h = count_h;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  typedef struct {
    logic       en;
    logic       up;
    logic       clr;
    logic [7:0] cb;
    logic       wb;
    logic [7:0] ch;
    logic       wh;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit         found;
    logic [1:0] pc;
    logic [1:0] ec;
    logic [6:0] es;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 8'h01, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h99, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h98, 1'b0, 8'hFE, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 8'h99, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 8'h99, 1'b1, 8'hFF, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};

    // Reset state
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("rst_count_bcd", 32'(count_b), 32'h00);
    check("rst_count_hex", 32'(count_h), 32'h00);
    check("rst_comm", 32'(comm_b), 32'h3);
    check("rst_seg", 32'(seg_b), 32'h00);
    check("rst_wrap", 32'(wrap_b), 32'h0);

    // One table row per step tick (4 cycles)
    for (int i = 0; i < 9; i++) begin
      EN  = vecs[i].en;
      UP  = vecs[i].up;
      CLR = vecs[i].clr;
      repeat (STEP_DIV) step();
      check($sformatf("vec%0d_count_bcd", i), 32'(count_b), 32'(vecs[i].cb));
      check($sformatf("vec%0d_wrap_bcd", i), 32'(wrap_b), 32'(vecs[i].wb));
      check($sformatf("vec%0d_count_hex", i), 32'(count_h), 32'(vecs[i].ch));
      check($sformatf("vec%0d_wrap_hex", i), 32'(wrap_h), 32'(vecs[i].wh));
      check($sformatf("vec%0d_dbg_hex", i), 32'(dbg_h), 32'(vecs[i].ch[3:0]));
    end
    CLR = 1'b0;

    // EN=0 freezes the count over 10 ticks
    EN = 1'b1;
    UP = 1'b1;
    repeat (STEP_DIV) step();
    check("pre_freeze_count", 32'(count_b), 32'h01);
    EN = 1'b0;
    for (int t = 0; t < 10; t++) begin
      repeat (STEP_DIV) step();
      check("freeze_count_bcd", 32'(count_b), 32'h01);
      check("freeze_count_hex", 32'(count_h), 32'h01);
    end

    // Count up from 01: decimal carry at 09->10, reach 45 (hex 2D)
    EN = 1'b1;
    for (int t = 1; t <= 44; t++) begin
      repeat (STEP_DIV) step();
      if (t == 9) begin
        check("carry_bcd_10", 32'(count_b), 32'h10);
        check("carry_hex_0a", 32'(count_h), 32'h0A);
      end
    end
    check("up_bcd_45", 32'(count_b), 32'h45);
    check("up_hex_2d", 32'(count_h), 32'h2D);

    // CLR during the tick cycle beats the step; prescaler phase is kept
    repeat (STEP_DIV - 1) step();
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    check("clr_tick_count_bcd", 32'(count_b), 32'h00);
    check("clr_tick_wrap_bcd", 32'(wrap_b), 32'h0);
    check("clr_tick_count_hex", 32'(count_h), 32'h00);
    repeat (STEP_DIV - 1) step();
    check("clr_phase_hold", 32'(count_b), 32'h00);
    step();
    check("clr_phase_step", 32'(count_b), 32'h01);

    // CLR mid-phase must not restart the prescaler
    step();
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    check("clr_mid_count", 32'(count_b), 32'h00);
    step();
    check("clr_mid_hold", 32'(count_b), 32'h00);
    step();
    check("clr_mid_step", 32'(count_b), 32'h01);

    // Bring the BCD counter to 21 and check the scan pattern
    repeat (20 * STEP_DIV) step();
    check("scan_count_21", 32'(count_b), 32'h21);
    EN = 1'b0;
    found = 1'b0;
    pc = comm_b;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (pc == 2'b01 && comm_b == 2'b11) found = 1'b1;
      else pc = comm_b;
    end
    check("scan_sync_found", 32'(found), 32'd1);
    if (found) begin
      for (int s = 0; s < 16; s++) begin
        if (s < 2)       begin ec = 2'b11; es = 7'h00; end
        else if (s < 8)  begin ec = 2'b10; es = 7'h06; end
        else if (s < 10) begin ec = 2'b11; es = 7'h00; end
        else             begin ec = 2'b01; es = 7'h5B; end
        check($sformatf("scan_comm_s%0d", s), 32'(comm_b), 32'(ec));
        check($sformatf("scan_seg_s%0d", s), 32'(seg_b), 32'(es));
        step();
      end
    end

    // Reset while digit 1 is driven
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (comm_b == 2'b01) found = 1'b1;
      else step();
    end
    check("rst_mid_found_drive", 32'(found), 32'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    EN  = 1'b1;
    UP  = 1'b1;
    check("rst_mid_comm", 32'(comm_b), 32'h3);
    check("rst_mid_seg", 32'(seg_b), 32'h00);
    check("rst_mid_count_bcd", 32'(count_b), 32'h00);
    check("rst_mid_count_hex", 32'(count_h), 32'h00);
    check("rst_mid_wrap", 32'(wrap_b), 32'h0);
    step();
    check("rst_slot1_comm", 32'(comm_b), 32'h3);
    step();
    check("rst_slot2_comm", 32'(comm_b), 32'h2);
    check("rst_slot2_seg", 32'(seg_b), 32'h3F);
    step();
    check("rst_step3_count", 32'(count_b), 32'h00);
    step();
    check("rst_step4_count", 32'(count_b), 32'h01);
    check("rst_step4_dbg", 32'(dbg_b), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_counter.md
SEG_SCAN_COUNTER -- requirements
Module: seg_scan_counter

Interface
REQ-001 SHALL have parameter NDIG, default 4, giving the number of digits and common-cathode lines (legal range 1..8).
REQ-002 SHALL have parameter BCD, default 1, selecting decimal digits (1, 0..9) or hex digits (0, 0..F).
REQ-003 SHALL have parameter STEP_DIV, default 12000000, giving CLK cycles per count step (1 Hz at 12 MHz); minimum 2.
REQ-004 SHALL have parameter SCAN_DIV, default 3000, giving CLK cycles per digit slot, including blanking; minimum BLANK+2.
REQ-005 SHALL have parameter BLANK, default 60, giving ghost-suppression cycles at the start of each slot, during which all COMM are high; minimum 1.
REQ-006 SHALL have port CLK, input, 1 bit: the sole clock (12 MHz board clock).
REQ-007 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port EN, input, 1 bit: count enable, sampled on step ticks only.
REQ-009 SHALL have port UP, input, 1 bit: count direction, 1 = increment, 0 = decrement.
REQ-010 SHALL have port CLR, input, 1 bit: synchronous clear of the count value.
REQ-011 SHALL have port SEG, output, 7 bits: segments, active high, with SEG[0]=a through SEG[6]=g.
REQ-012 SHALL have port COMM, output, NDIG bits: digit commons, active low; COMM[0] is the least significant digit.
REQ-013 SHALL have port COUNT, output, 4*NDIG bits: current count, one nibble per digit, digit 0 in bits [3:0].
REQ-014 SHALL have port WRAP, output, 1 bit: single-cycle pulse on overflow or underflow.
REQ-015 SHALL have port DBG, output, 4 bits: least significant digit value, driven from COUNT[3:0].

Function
REQ-016 Step prescaler SHALL count 0..STEP_DIV-1 and then return to 0; the internal tick SHALL be asserted for the one cycle in which it equals STEP_DIV-1.
REQ-017 On a cycle with tick=1 and EN=1, the count SHALL change by exactly one in the UP direction on the following edge; EN=0 SHALL hold the count, and the prescaler SHALL run regardless of EN.
REQ-018 Digit arithmetic SHALL use a per-digit carry/borrow chain with each digit max = 9 if BCD=1, else 15.
  - Increment: a digit at max becomes 0 and carries.
  - Decrement: a digit at 0 becomes max and borrows.
REQ-019 Increment from all-max SHALL produce all-zero, and decrement from all-zero SHALL produce all-max; WRAP SHALL be 1 in the cycle after the wrapping edge only.
REQ-020 CLR=1 SHALL force the count to 0 on the next edge, taking priority over a simultaneous tick, and SHALL suppress WRAP; CLR SHALL NOT reset either prescaler.
REQ-021 COUNT, WRAP, SEG and COMM SHALL all be registered outputs.
REQ-022 The scan FSM SHALL have two states, BLANKING and DRIVE, with a slot counter running 0..SCAN_DIV-1.
  - BLANKING while the slot counter < BLANK.
  - DRIVE from BLANK through SCAN_DIV-1.
  - On SCAN_DIV-1, the digit index SHALL advance (NDIG-1 wraps to 0) and the FSM SHALL re-enter BLANKING.
REQ-023 In BLANKING, COMM SHALL be all ones and SEG SHALL be 0.
REQ-024 In DRIVE, COMM SHALL be all ones except bit [index], which is 0, and SEG SHALL be the decode of the digit at [index] as sampled from COUNT in that same cycle.
REQ-025 The decoder SHALL produce these patterns (g..a): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-026 With BCD=1, digit values 10..15 SHALL be unreachable; if present they SHALL decode to SEG=0.
REQ-027 At most one COMM bit SHALL be low in any cycle, and a COMM change between digits SHALL always pass through at least BLANK all-high cycles.

Reset
REQ-028 RST=1 at a clock edge SHALL clear the following: count=0, both prescalers=0, digit index=0, FSM=BLANKING, COMM=all ones, SEG=0, WRAP=0.
REQ-029 RST SHALL take priority over CLR, EN and tick, and SHALL take effect mid-slot or mid-step with no partial update.
REQ-030 On the first edge after RST falls, the slot counter SHALL be 1 and the step prescaler SHALL be 1.
REQ-031 Every output SHALL be defined, with no X, from the first edge with RST=1.

Verification (NDIG=2, STEP_DIV=4, SCAN_DIV=8, BLANK=2 unless stated)
REQ-032 Bench SHALL cover BCD roll: BCD=1, EN=1, UP=1 from 0x98, two ticks -> COUNT=0x99, then 0x00 with one WRAP pulse; ticks SHALL be exactly 4 cycles apart.
REQ-033 Bench SHALL cover hex down-wrap: BCD=0, UP=0 from 0x00, one tick -> COUNT=0xFF and WRAP=1 for one cycle.
REQ-034 Bench SHALL cover scan timing: COUNT=0x21 -> COMM pattern repeats 11 x2, 10 x6, 11 x2, 01 x6; SEG=0000110 while COMM=10 and SEG=1011011 while COMM=01.
REQ-035 Bench SHALL cover CLR in a tick cycle from 0x45 -> next COUNT=0x00 and WRAP=0; the prescaler phase SHALL be unchanged.
REQ-036 Bench SHALL cover reset mid-DRIVE: RST=1 for one edge during digit 1 -> COMM=11, SEG=0, COUNT=0; the first DRIVE afterwards SHALL select digit 0 at slot cycle 2.
REQ-037 Bench SHALL check throughout every run that COMM has at most one low bit, that EN=0 freezes COUNT across 10 ticks, and that WRAP never lasts more than one cycle.
